// File: rtl/miriscv_uart_pkg.sv
// Shared types and helpers for the miriscv UART receiver: frame FSM states,
// parity modes, FIFO entry layout and the data-bits encoding.
package miriscv_uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2,
        PAR_RSVD = 2'd3
    } uart_parity_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } uart_rx_state_e;

    typedef struct packed {
        logic       ferr;
        logic       perr;
        logic [7:0] data;
    } uart_rx_entry_t;

    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    // Unused data bits are held at zero, so they never disturb the reduction.
    function automatic logic parity_expected(input logic [7:0] data, input uart_parity_e par);
        logic exp_bit;
        case (par)
            PAR_ODD:  exp_bit = ~^data;
            PAR_EVEN: exp_bit = ^data;
            default:  exp_bit = ^data;
        endcase
        return exp_bit;
    endfunction

    function automatic logic [2:0] last_bit_idx(input logic [1:0] data_bits);
        return {1'b0, data_bits} + 3'd4;
    endfunction

endpackage

// File: rtl/miriscv_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through output, flush, and
// extra-bit pointers for full/empty; a pop frees room for a same-cycle push.
module miriscv_sync_fifo #(
    parameter int unsigned WIDTH = 10,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      level_o
);

    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             empty_s;
    logic             full_s;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_s   = (wr_ptr_r == rd_ptr_r);
    assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop_i & ~empty_s;
    assign do_push_s = push_i & (~full_s | do_pop_s);

    // Pointer update; flush wins over any push or pop in the same cycle.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        if (do_push_s && !flush_i) begin
            mem_r[wr_ptr_r[AW-1:0]] <= data_i;
        end
    end

    // Head entry, forced to zero while empty so stale words never show.
    always_comb begin
        if (empty_s) begin
            data_o = {WIDTH{1'b0}};
        end else begin
            data_o = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

    assign full_o  = full_s;
    assign empty_o = empty_s;
    assign level_o = wr_ptr_r - rd_ptr_r;

endmodule

// File: rtl/miriscv_uart_rx_fifo.sv
// Run-time configurable UART receiver (5-8 data bits, none/even/odd parity,
// 1 or 2 stop bits) feeding a receive FIFO read out as a valid/ready stream.
module miriscv_uart_rx_fifo
    import miriscv_uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          arstn_i,
    input  logic                          uart_rx_i,
    input  logic [DIV_W-1:0]              cfg_div_i,
    input  logic [1:0]                    cfg_data_bits_i,
    input  logic [1:0]                    cfg_parity_i,
    input  logic                          cfg_stop2_i,
    output logic [7:0]                    m_data_o,
    output logic                          m_perr_o,
    output logic                          m_ferr_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic                          overrun_o,
    input  logic                          clr_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    logic [1:0]           sync_r;
    logic                 rx_s;
    logic                 rx_prev_r;
    logic                 fall_s;
    logic [DIV_W-1:0]     div_r;
    logic [DIV_W-1:0]     div_cnt_r;
    logic                 tick_s;
    logic [OS_W-1:0]      os_cnt_r;
    logic                 sample_s;
    logic                 bit_end_s;
    uart_rx_state_e       state_r;
    logic [1:0]           data_bits_r;
    uart_parity_e         parity_r;
    logic                 stop2_r;
    logic [2:0]           bit_idx_r;
    logic [7:0]           shift_r;
    logic                 perr_r;
    logic                 push_r;
    uart_rx_entry_t       push_entry_r;
    uart_rx_entry_t       fifo_out_s;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 overrun_r;

    assign rx_s      = sync_r[1];
    assign fall_s    = rx_prev_r & ~rx_s;
    assign tick_s    = (state_r != ST_IDLE) && (div_cnt_r == {DIV_W{1'b0}});
    assign sample_s  = tick_s && (os_cnt_r == OS_MID);
    assign bit_end_s = tick_s && (os_cnt_r == OS_LAST);

    // Two-flop synchroniser plus one delayed copy for start-edge detection.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_r    <= 2'b11;
            rx_prev_r <= 1'b1;
        end else begin
            sync_r    <= {sync_r[0], uart_rx_i};
            rx_prev_r <= sync_r[1];
        end
    end

    // Oversample tick divider; parked at zero in IDLE so the first tick of a frame is immediate.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            div_cnt_r <= {DIV_W{1'b0}};
        end else if (div_cnt_r == {DIV_W{1'b0}}) begin
            div_cnt_r <= div_r;
        end else begin
            div_cnt_r <= div_cnt_r - {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Frame receiver FSM with latched configuration and registered push.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_r      <= ST_IDLE;
            os_cnt_r     <= {OS_W{1'b0}};
            div_r        <= {DIV_W{1'b0}};
            data_bits_r  <= DATA_BITS_5;
            parity_r     <= PAR_NONE;
            stop2_r      <= 1'b0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            perr_r       <= 1'b0;
            push_r       <= 1'b0;
            push_entry_r <= '{ferr: 1'b0, perr: 1'b0, data: 8'h00};
        end else begin
            push_r <= 1'b0;
            if (tick_s) begin
                os_cnt_r <= bit_end_s ? {OS_W{1'b0}} : os_cnt_r + {{(OS_W-1){1'b0}}, 1'b1};
            end
            case (state_r)
                ST_IDLE: begin
                    os_cnt_r <= {OS_W{1'b0}};
                    if (fall_s) begin
                        state_r     <= ST_START;
                        div_r       <= cfg_div_i;
                        data_bits_r <= cfg_data_bits_i;
                        parity_r    <= (uart_parity_e'(cfg_parity_i) == PAR_RSVD) ?
                                       PAR_NONE : uart_parity_e'(cfg_parity_i);
                        stop2_r     <= cfg_stop2_i;
                        bit_idx_r   <= 3'd0;
                        shift_r     <= 8'h00;
                        perr_r      <= 1'b0;
                    end
                end
                ST_START: begin
                    if (sample_s && rx_s) begin
                        state_r <= ST_IDLE;
                    end else if (bit_end_s) begin
                        state_r <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (sample_s) begin
                        shift_r[bit_idx_r] <= rx_s;
                    end
                    if (bit_end_s) begin
                        if (bit_idx_r == last_bit_idx(data_bits_r)) begin
                            state_r <= (parity_r == PAR_NONE) ? ST_STOP1 : ST_PARITY;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (sample_s) begin
                        perr_r <= (rx_s != parity_expected(shift_r, parity_r));
                    end
                    if (bit_end_s) begin
                        state_r <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    // A good first stop bit with two configured keeps the tick phase running into STOP2.
                    if (sample_s) begin
                        if (stop2_r && rx_s) begin
                            state_r <= ST_STOP2;
                        end else begin
                            push_r       <= 1'b1;
                            push_entry_r <= '{ferr: ~rx_s, perr: perr_r, data: shift_r};
                            state_r      <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (sample_s) begin
                        push_r       <= 1'b1;
                        push_entry_r <= '{ferr: ~rx_s, perr: perr_r, data: shift_r};
                        state_r      <= rx_s ? ST_IDLE : ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overrun: a push into a full FIFO with no pop to make room.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            overrun_r <= 1'b0;
        end else if (clr_i) begin
            overrun_r <= 1'b0;
        end else if (push_r && fifo_full_s && !m_ready_i) begin
            overrun_r <= 1'b1;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    miriscv_sync_fifo #(
        .WIDTH ($bits(uart_rx_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .flush_i (clr_i),
        .push_i  (push_r),
        .data_i  (push_entry_r),
        .pop_i   (m_ready_i),
        .data_o  (fifo_out_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .level_o (level_o)
    );

    assign m_data_o  = fifo_out_s.data;
    assign m_perr_o  = fifo_out_s.perr;
    assign m_ferr_o  = fifo_out_s.ferr;
    assign m_valid_o = ~fifo_empty_s;
    assign overrun_o = overrun_r;
    assign busy_o    = (state_r != ST_IDLE);

endmodule
